// File: rtl/stepdown_core_state_seq.sv
// Start-up/fault sequencer for the stepdown core-state gate: IDLE -> PRECHG -> SS -> RUN, with FAULT latch.
// Optional hiccup retry after cooldown is enabled by defining STEPDOWN_HICCUP_EN.
module stepdown_core_state_seq #(
    parameter int PRECHG_CYC = 64,
    parameter int SS_STEPS   = 32,
    parameter int SSW        = 5,
    parameter int SS_DIV     = 16,
    parameter int COOL_CYC   = 1024,
    parameter int RETRY_MAX  = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           uvlo_ok,
    input  logic           vout_ok,
    input  logic           ocp,
    input  logic           i0,
    output logic           o,
    output logic           Tstate,
    output logic [SSW-1:0] ss_code,
    output logic           pgood,
    output logic           fault,
    output logic [2:0]     state,
    input  logic           CELG,
    input  logic           CELV,
    input  logic           CELSUB
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRECHG = 3'd1,
        SS     = 3'd2,
        RUN    = 3'd3,
        FAULT  = 3'd4
    } state_e;

    localparam int CNT_MAX = (PRECHG_CYC > SS_DIV) ? PRECHG_CYC : SS_DIV;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0]  PRE_LAST = CW'(PRECHG_CYC - 1);
    localparam logic [CW-1:0]  SS_LAST  = CW'(SS_DIV - 1);
    localparam logic [SSW-1:0] SS_TOP   = SSW'(SS_STEPS - 1);

    state_e         state_q, state_d;
    logic           tstate_q, tstate_d;
    logic [SSW-1:0] ss_code_q, ss_code_d;
    logic           pgood_q, pgood_d;
    logic           fault_q, fault_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ocp_qual_q, ocp_qual_d;
    logic           uv_qual_q, uv_qual_d;
    logic           enter_fault;
    logic           force_idle;

`ifdef STEPDOWN_HICCUP_EN
    localparam int CCW = (COOL_CYC > 2) ? $clog2(COOL_CYC) : 1;
    localparam int RW  = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [CCW-1:0] COOL_LAST = CCW'(COOL_CYC - 1);
    localparam logic [RW-1:0]  RETRY_LIM = RW'(RETRY_MAX);

    logic [CCW-1:0] cool_cnt_q, cool_cnt_d;
    logic [RW-1:0]  retry_cnt_q, retry_cnt_d;
`endif

    always_comb begin
        // NOTE: every _d gets a hold/clear default first so no path can infer a latch.
        state_d     = state_q;
        tstate_d    = tstate_q;
        ss_code_d   = ss_code_q;
        pgood_d     = pgood_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;
        ocp_qual_d  = 1'b0;
        uv_qual_d   = 1'b0;
        enter_fault = 1'b0;
        force_idle  = 1'b0;
`ifdef STEPDOWN_HICCUP_EN
        cool_cnt_d  = cool_cnt_q;
        retry_cnt_d = retry_cnt_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef STEPDOWN_HICCUP_EN
                retry_cnt_d = '0;
`endif
                if (uvlo_ok) begin
                    state_d = PRECHG;
                    cnt_d   = '0;
                end
            end
            PRECHG: begin
                if (cnt_q == PRE_LAST) begin
                    state_d   = SS;
                    tstate_d  = 1'b1;
                    ss_code_d = '0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SS: begin
                ocp_qual_d = ocp;
                if (ocp && ocp_qual_q) begin
                    enter_fault = 1'b1;
                end else if (ss_code_q == SS_TOP) begin
                    // Once the ramp is saturated, cnt_q doubles as the UV timeout.
                    if (vout_ok) begin
                        state_d = RUN;
                        pgood_d = 1'b1;
                        cnt_d   = '0;
                    end else if (cnt_q == SS_LAST) begin
                        enter_fault = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_q == SS_LAST) begin
                    cnt_d     = '0;
                    ss_code_d = ss_code_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                ocp_qual_d = ocp;
                uv_qual_d  = !vout_ok;
                if ((ocp && ocp_qual_q) || (!vout_ok && uv_qual_q)) begin
                    enter_fault = 1'b1;
                end
            end
            FAULT: begin
`ifdef STEPDOWN_HICCUP_EN
                if (cool_cnt_q == COOL_LAST) begin
                    if (retry_cnt_q < RETRY_LIM) begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        fault_d     = 1'b0;
                        state_d     = PRECHG;
                        cnt_d       = '0;
                    end
                end else begin
                    cool_cnt_d = cool_cnt_q + 1'b1;
                end
`endif
            end
            default: force_idle = 1'b1;
        endcase

        if (enter_fault) begin
            state_d    = FAULT;
            tstate_d   = 1'b0;
            pgood_d    = 1'b0;
            ss_code_d  = '0;
            fault_d    = 1'b1;
            cnt_d      = '0;
            ocp_qual_d = 1'b0;
            uv_qual_d  = 1'b0;
`ifdef STEPDOWN_HICCUP_EN
            cool_cnt_d = '0;
`endif
        end

        // en drop beats everything; UVLO loss aborts the sequence but leaves a latched FAULT alone.
        if (force_idle || !en || (!uvlo_ok && state_q != FAULT)) begin
            state_d    = IDLE;
            tstate_d   = 1'b0;
            pgood_d    = 1'b0;
            ss_code_d  = '0;
            fault_d    = 1'b0;
            cnt_d      = '0;
            ocp_qual_d = 1'b0;
            uv_qual_d  = 1'b0;
`ifdef STEPDOWN_HICCUP_EN
            cool_cnt_d  = '0;
            retry_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tstate_q    <= 1'b0;
            ss_code_q   <= '0;
            pgood_q     <= 1'b0;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
            ocp_qual_q  <= 1'b0;
            uv_qual_q   <= 1'b0;
`ifdef STEPDOWN_HICCUP_EN
            cool_cnt_q  <= '0;
            retry_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tstate_q    <= tstate_d;
            ss_code_q   <= ss_code_d;
            pgood_q     <= pgood_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
            ocp_qual_q  <= ocp_qual_d;
            uv_qual_q   <= uv_qual_d;
`ifdef STEPDOWN_HICCUP_EN
            cool_cnt_q  <= cool_cnt_d;
            retry_cnt_q <= retry_cnt_d;
`endif
        end
    end

    assign o       = i0 & tstate_q;
    assign Tstate  = tstate_q;
    assign ss_code = ss_code_q;
    assign pgood   = pgood_q;
    assign fault   = fault_q;
    assign state   = state_q;

    // Supply/substrate pins only feed the physical gate cells.
    logic unused_supply;
    assign unused_supply = &{1'b0, CELG, CELV, CELSUB};

endmodule

// File: tb/tb_stepdown_core_state_seq.sv
// Directed, table-driven bench for stepdown_core_state_seq (default parameters).
// Hiccup sequence is exercised when STEPDOWN_HICCUP_EN is defined; otherwise the long fault latch is checked.
module tb_stepdown_core_state_seq;

    localparam int ST_IDLE = 0, ST_PRE = 1, ST_SS = 2, ST_RUN = 3, ST_FLT = 4;

    logic       clk = 1'b0;
    logic       rst, en, uvlo_ok, vout_ok, ocp, i0;
    logic       o, Tstate, pgood, fault;
    logic [4:0] ss_code;
    logic [2:0] state;

    int n_vec = 0;
    int n_bad = 0;

    stepdown_core_state_seq dut (
        .clk(clk), .rst(rst), .en(en), .uvlo_ok(uvlo_ok), .vout_ok(vout_ok),
        .ocp(ocp), .i0(i0), .o(o), .Tstate(Tstate), .ss_code(ss_code),
        .pgood(pgood), .fault(fault), .state(state),
        .CELG(1'b1), .CELV(1'b1), .CELSUB(1'b0)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  en, uvlo_ok, vout_ok, ocp, i0;
        int    n;
        int    st;
        logic  ts;
        int    ss;
        logic  pg, flt, o;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic e, input logic u, input logic v,
                       input logic oc, input logic d, input int n, input int st,
                       input logic ts, input int ss, input logic pg, input logic flt,
                       input logic ov);
        vec_t t;
        t.name = nm; t.en = e; t.uvlo_ok = u; t.vout_ok = v; t.ocp = oc; t.i0 = d;
        t.n = n; t.st = st; t.ts = ts; t.ss = ss; t.pg = pg; t.flt = flt; t.o = ov;
        vecs.push_back(t);
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 ns after each edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string nm, input int st, input logic ts, input int ss,
                         input logic pg, input logic flt, input logic ov);
        logic [11:0] act, exp;
        act = {state, Tstate, ss_code, pgood, fault, o};
        exp = {st[2:0], ts, ss[4:0], pg, flt, ov};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got state=%0d T=%b ss=%0d pg=%b flt=%b o=%b, want state=%0d T=%b ss=%0d pg=%b flt=%b o=%b",
                     nm, state, Tstate, ss_code, pgood, fault, o, st, ts, ss, pg, flt, ov);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic e, input logic u, input logic v, input logic oc, input logic d);
        en = e; uvlo_ok = u; vout_ok = v; ocp = oc; i0 = d;
    endtask

    initial begin
        //   name            en u v oc i0  n    state   T ss pg f o
        add("idle",          0, 1, 1, 0, 1, 3,   ST_IDLE, 0, 0, 0, 0, 0);
        add("en_prechg",     1, 1, 1, 0, 1, 1,   ST_PRE,  0, 0, 0, 0, 0);
        add("prechg_63",     1, 1, 1, 0, 1, 63,  ST_PRE,  0, 0, 0, 0, 0);
        add("ss_entry",      1, 1, 1, 0, 1, 1,   ST_SS,   1, 0, 0, 0, 1);
        add("ss_i0_low",     1, 1, 1, 0, 0, 15,  ST_SS,   1, 0, 0, 0, 0);
        add("ss_step1",      1, 1, 1, 0, 1, 1,   ST_SS,   1, 1, 0, 0, 1);
        add("ss_step30",     1, 1, 1, 0, 1, 464, ST_SS,   1, 30, 0, 0, 1);
        add("ss_sat",        1, 1, 1, 0, 1, 16,  ST_SS,   1, 31, 0, 0, 1);
        add("run",           1, 1, 1, 0, 1, 1,   ST_RUN,  1, 31, 1, 0, 1);
        add("ocp_glitch",    1, 1, 1, 1, 1, 1,   ST_RUN,  1, 31, 1, 0, 1);
        add("ocp_gap",       1, 1, 1, 0, 1, 2,   ST_RUN,  1, 31, 1, 0, 1);
        add("ocp_1st",       1, 1, 1, 1, 1, 1,   ST_RUN,  1, 31, 1, 0, 1);
        add("ocp_fault",     1, 1, 1, 1, 1, 1,   ST_FLT,  0, 0, 0, 1, 0);
        add("flt_uvlo_low",  1, 0, 1, 0, 1, 5,   ST_FLT,  0, 0, 0, 1, 0);
        add("flt_en_off",    0, 1, 1, 0, 1, 1,   ST_IDLE, 0, 0, 0, 0, 0);
        add("t4_prechg",     1, 1, 1, 0, 1, 1,   ST_PRE,  0, 0, 0, 0, 0);
        add("t4_ss",         1, 1, 1, 0, 1, 64,  ST_SS,   1, 0, 0, 0, 1);
        add("t4_ss10",       1, 1, 1, 0, 1, 160, ST_SS,   1, 10, 0, 0, 1);
        add("t4_en_off",     0, 1, 1, 0, 1, 1,   ST_IDLE, 0, 0, 0, 0, 0);
        add("t4_restart",    1, 1, 1, 0, 1, 1,   ST_PRE,  0, 0, 0, 0, 0);
        add("t4_ss_again",   1, 1, 1, 0, 1, 64,  ST_SS,   1, 0, 0, 0, 1);
        add("t4_off2",       0, 1, 1, 0, 1, 1,   ST_IDLE, 0, 0, 0, 0, 0);
        add("uv_to_ss",      1, 1, 1, 0, 1, 65,  ST_SS,   1, 0, 0, 0, 1);
        add("uv_to_run",     1, 1, 1, 0, 1, 497, ST_RUN,  1, 31, 1, 0, 1);
        add("uv_1cyc",       1, 1, 0, 0, 1, 1,   ST_RUN,  1, 31, 1, 0, 1);
        add("uv_recover",    1, 1, 1, 0, 1, 1,   ST_RUN,  1, 31, 1, 0, 1);
        add("uv_fault",      1, 1, 0, 0, 1, 2,   ST_FLT,  0, 0, 0, 1, 0);
        add("uv_off",        0, 1, 1, 0, 1, 1,   ST_IDLE, 0, 0, 0, 0, 0);
        add("uvlo_pre",      1, 1, 1, 0, 1, 1,   ST_PRE,  0, 0, 0, 0, 0);
        add("uvlo_abort",    1, 0, 1, 0, 1, 1,   ST_IDLE, 0, 0, 0, 0, 0);
        add("uvlo_hold",     1, 0, 1, 0, 1, 2,   ST_IDLE, 0, 0, 0, 0, 0);
        add("uvlo_back",     1, 1, 1, 0, 1, 1,   ST_PRE,  0, 0, 0, 0, 0);
        add("uvlo_off",      0, 1, 1, 0, 1, 1,   ST_IDLE, 0, 0, 0, 0, 0);
        add("ssocp_to_ss",   1, 1, 1, 0, 1, 65,  ST_SS,   1, 0, 0, 0, 1);
        add("ssocp_fault",   1, 1, 1, 1, 1, 2,   ST_FLT,  0, 0, 0, 1, 0);
        add("ssocp_off",     0, 1, 1, 0, 1, 1,   ST_IDLE, 0, 0, 0, 0, 0);

        rst = 1'b1;
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(2);
        check("reset", ST_IDLE, 0, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            set_in(vecs[k].en, vecs[k].uvlo_ok, vecs[k].vout_ok, vecs[k].ocp, vecs[k].i0);
            tick(vecs[k].n);
            check(vecs[k].name, vecs[k].st, vecs[k].ts, vecs[k].ss, vecs[k].pg, vecs[k].flt, vecs[k].o);
        end

        // UV timeout: vout_ok never asserts during the ramp.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(65);
        check("uvt_ss", ST_SS, 1, 0, 0, 0, 1);
        tick(496);
        check("uvt_sat", ST_SS, 1, 31, 0, 0, 1);
        tick(15);
        check("uvt_wait15", ST_SS, 1, 31, 0, 0, 1);
        tick(1);
        check("uvt_fault", ST_FLT, 0, 0, 0, 1, 0);

`ifdef STEPDOWN_HICCUP_EN
        en = 1'b0;
        tick(1);
        check("hic_idle0", ST_IDLE, 0, 0, 0, 0, 0);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(562);
        check("hic_run", ST_RUN, 1, 31, 1, 0, 1);
        ocp = 1'b1;
        tick(2);
        check("hic_fault0", ST_FLT, 0, 0, 0, 1, 0);
        for (int r = 1; r <= 3; r++) begin
            tick(1023);
            check($sformatf("hic_cool%0d", r), ST_FLT, 0, 0, 0, 1, 0);
            tick(1);
            check($sformatf("hic_retry%0d", r), ST_PRE, 0, 0, 0, 0, 0);
            check_bit($sformatf("hic_cnt%0d", r), (int'(dut.retry_cnt_q) == r), 1'b1);
            tick(64);
            check($sformatf("hic_ss%0d", r), ST_SS, 1, 0, 0, 0, 1);
            tick(2);
            check($sformatf("hic_refault%0d", r), ST_FLT, 0, 0, 0, 1, 0);
        end
        tick(1124);
        check("hic_latched", ST_FLT, 0, 0, 0, 1, 0);
        en = 1'b0;
        ocp = 1'b0;
        tick(1);
        check("hic_en_off", ST_IDLE, 0, 0, 0, 0, 0);
        check_bit("hic_retry_clr", (dut.retry_cnt_q == '0), 1'b1);
`else
        begin
            logic left_fault;
            left_fault = 1'b0;
            for (int c = 0; c < 5000; c++) begin
                tick(1);
                if (state !== 3'(ST_FLT) || fault !== 1'b1 || Tstate !== 1'b0) left_fault = 1'b1;
            end
            check_bit("uvt_latched_5000", left_fault, 1'b0);
        end
        en = 1'b0;
        tick(1);
        check("uvt_en_off", ST_IDLE, 0, 0, 0, 0, 0);
`endif

        // Synchronous reset in RUN clears everything on the same edge.
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(562);
        check("rst_run", ST_RUN, 1, 31, 1, 0, 1);
        rst = 1'b1;
        tick(1);
        check("rst_mid_run", ST_IDLE, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick(1);
        check("rst_release", ST_PRE, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
